frame_capture: RTL
==================

FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 Parameters: none; geometry constants come from frame_capture_pkg.
REQ-002 clock  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pix_valid  input  1  a pixel is presented this cycle.
REQ-005 x  input  8  pixel column, legal range 0..159.
REQ-006 y  input  7  pixel row, legal range 1..120; y=120 is the first row of a frame.
REQ-007 color  input  3  pixel color.
REQ-008 color_foreground  input  3  a pixel whose color equals this value stores 1; any other value stores 0.
REQ-009 continuous  input  1  1: re-arm after each frame; 0: single-shot.
REQ-010 capture_req  input  1  single-cycle pulse that arms a capture from IDLE.
REQ-011 image  output  19200  last completed frame; bit 19199-idx holds pixel idx.
REQ-012 frame_valid  output  1  one-cycle pulse when image updates.
REQ-013 busy  output  1  high in ARM or CAPTURE.
REQ-014 sync_err  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-015 idx SHALL be (120-y)*160+x, computed at full width with no truncation.
REQ-016 A pixel is legal only when 0<=x<=159 and 1<=y<=120.
REQ-017 FSM states SHALL be IDLE, ARM, CAPTURE, DONE.
REQ-018 IDLE: capture_req=1 or continuous=1 SHALL move to ARM on the next cycle.
REQ-019 ARM: pixels are ignored until a valid pixel with x=0, y=120 arrives.
REQ-020 On that start pixel: write bit 19199 of the back buffer, set expected index to 1, and enter CAPTURE.
REQ-021 CAPTURE, valid pixel whose idx equals the expected index: write back-buffer bit 19199-idx and increment the expected index.
REQ-022 CAPTURE, valid pixel that is illegal or out of sequence: pulse sync_err and go to ARM.
REQ-023 On a REQ-022 abort, the same pixel SHALL be re-evaluated as a start pixel in that cycle, so a start pixel restarts the capture.
REQ-024 CAPTURE, idx=19199 accepted: next cycle copy the back buffer into image, pulse frame_valid, and enter DONE.
REQ-025 DONE lasts exactly 1 cycle; it then goes to ARM if continuous=1, else IDLE.
REQ-026 A pixel arriving in DONE is treated as in ARM, so back-to-back frames lose no pixel.
REQ-027 Cycles with pix_valid=0 SHALL leave all state unchanged; gaps are legal.
REQ-028 capture_req outside IDLE SHALL be ignored.
REQ-029 image SHALL change only at frame completion; a partial frame is never visible.

Reset
REQ-030 Reset SHALL set state IDLE, image all-zero, back buffer all-zero, expected index 0, and frame_valid, busy, sync_err to 0.
REQ-031 Reset has priority over all inputs; reset during CAPTURE SHALL discard the partial frame.

Configuration
REQ-032 Macro FRAME_CAPTURE_ERRCNT_EN, when defined, SHALL add output err_count [7:0].
REQ-033 err_count increments on each sync_err pulse, saturates at 255, and is cleared only by reset.
REQ-034 Without the macro, the err_count port and its logic SHALL NOT exist; all other behaviour is identical.

Structure
REQ-035 frame_capture_pkg SHALL hold WIDTH=160, HEIGHT=120, NPIX=19200, Y_TOP=120, IDX_W=15, and the FSM state enum.
REQ-036 One sub-module, pixel_addr, SHALL be combinational: x,y in; idx and legal out.

Verification
REQ-037 Full frame: raster x=0..159 per row, y=120 down to 1, color=fg on even idx and 0 elsewhere -> frame_valid 1 cycle after idx 19199; image alternates 1,0 from bit 19199; sync_err never pulses.
REQ-038 Skip: frame with idx 500 omitted -> sync_err pulse at idx 501; no frame_valid; image unchanged.
REQ-039 Illegal pixel: x=160 or y=0 mid-frame -> sync_err; FSM enters ARM.
REQ-040 Continuous mode: two back-to-back frames with no idle cycle -> two frame_valid pulses 19200 cycles apart; second image correct.
REQ-041 Reset mid-frame: reset at idx 10000, then a full frame -> image reflects only the post-reset frame.
REQ-042 Macro defined: 300 aborted frames -> err_count=255.

Source files
------------

// File: rtl/frame_capture_pkg.sv
// -----------------------------------------------------------------------------
// frame_capture_pkg
// Purpose : shared geometry constants, port widths and the capture FSM state
//           type for the frame_capture block.
// Contents: WIDTH/HEIGHT/NPIX/Y_TOP/IDX_W geometry, X_W/Y_W/COLOR_W/ERRCNT_W
//           port widths, state_t (IDLE, ARM, CAPTURE, DONE).
// -----------------------------------------------------------------------------
package frame_capture_pkg;

    // Frame geometry; rows arrive top-down starting at y = Y_TOP.
    localparam int unsigned WIDTH    = 160;
    localparam int unsigned HEIGHT   = 120;
    localparam int unsigned NPIX     = WIDTH * HEIGHT;
    localparam int unsigned Y_TOP    = 120;
    localparam int unsigned IDX_W    = 15;

    // Port widths
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned ERRCNT_W = 8;

    // Capture sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage : frame_capture_pkg

// File: rtl/frame_capture_pixel_addr.sv
// -----------------------------------------------------------------------------
// pixel_addr
// Purpose : combinational raster address of a pixel coordinate.
// Ports   : x     [X_W-1:0]   pixel column
//           y     [Y_W-1:0]   pixel row (Y_TOP is the first row of a frame)
//           idx   [IDX_W-1:0] raster index (Y_TOP - y) * WIDTH + x, 0 when illegal
//           legal             coordinate lies inside the frame
// -----------------------------------------------------------------------------
module pixel_addr
    import frame_capture_pkg::*;
(
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    output logic [IDX_W-1:0] idx,
    output logic             legal
);

    logic        x_ok;
    logic        y_ok;
    logic        in_range;
    logic [31:0] idx_full;

    // Address is formed at 32 bits so rows above Y_TOP wrap far out of range
    // instead of aliasing onto a real pixel.
    always_comb begin
        x_ok     = (32'(x) < WIDTH);
        y_ok     = (y != '0) && (32'(y) <= HEIGHT);
        idx_full = (32'(Y_TOP) - 32'(y)) * 32'(WIDTH) + 32'(x);
        // Redundant with the row/column checks; guards the full-width sum.
        in_range = (idx_full < 32'(NPIX));
        legal    = x_ok && y_ok && in_range;
        idx      = legal ? idx_full[IDX_W-1:0] : '0;
    end

endmodule : pixel_addr

// File: rtl/frame_capture.sv
// -----------------------------------------------------------------------------
// frame_capture
// Purpose : captures a raster-ordered stream of pixels into a 1-bit-per-pixel
//           back buffer (1 = pixel color matches color_foreground) and
//           publishes it to image only when a complete, in-order frame has
//           been received. Out-of-order or illegal pixels abort the frame.
// Ports   : clock, reset            single clock, synchronous active-high reset
//           pix_valid, x, y, color  pixel stream
//           color_foreground        color that stores a 1
//           continuous              re-arm automatically after each frame
//           capture_req             one-shot arm request (honoured in IDLE only)
//           image [NPIX-1:0]        last completed frame, bit NPIX-1-idx = pixel idx
//           frame_valid             one-cycle pulse when image updates
//           busy                    high while in ARM or CAPTURE
//           sync_err                one-cycle pulse when a frame is aborted
//           err_count [7:0]         saturating abort counter (FRAME_CAPTURE_ERRCNT_EN)
// Config  : define FRAME_CAPTURE_ERRCNT_EN to add the err_count output.
// -----------------------------------------------------------------------------
module frame_capture
    import frame_capture_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                pix_valid,
    input  logic [X_W-1:0]      x,
    input  logic [Y_W-1:0]      y,
    input  logic [COLOR_W-1:0]  color,
    input  logic [COLOR_W-1:0]  color_foreground,
    input  logic                continuous,
    input  logic                capture_req,
    output logic [NPIX-1:0]     image,
    output logic                frame_valid,
    output logic                busy,
    output logic                sync_err
`ifdef FRAME_CAPTURE_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    state_t           state;
    logic [NPIX-1:0]  back_buf;
    logic [IDX_W-1:0] exp_idx;

    logic [IDX_W-1:0] pix_idx;
    logic             pix_legal;
    logic             fg_bit;
    logic             start_hit;
    logic             seq_hit;
    logic             last_hit;
    logic [IDX_W-1:0] buf_pos;

    pixel_addr u_pixel_addr (
        .x     (x),
        .y     (y),
        .idx   (pix_idx),
        .legal (pix_legal)
    );

    // Per-pixel decode: start-of-frame, in-sequence and last-pixel qualifiers.
    always_comb begin
        fg_bit    = (color == color_foreground);
        start_hit = pix_valid && pix_legal && (pix_idx == '0);
        seq_hit   = pix_valid && pix_legal && (pix_idx == exp_idx);
        last_hit  = (pix_idx == IDX_W'(NPIX - 1));
        buf_pos   = IDX_W'(NPIX - 1) - pix_idx;
    end

    // Capture FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            back_buf    <= '0;
            image       <= '0;
            exp_idx     <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            sync_err    <= 1'b0;
`ifdef FRAME_CAPTURE_ERRCNT_EN
            err_count   <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;

            case (state)
                IDLE: begin
                    if (capture_req || continuous) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end

                // DONE accepts a start pixel like ARM so back-to-back frames
                // need no spare cycle between them.
                ARM, DONE: begin
                    if (start_hit) begin
                        back_buf[NPIX-1] <= fg_bit;
                        exp_idx          <= IDX_W'(1);
                        state            <= CAPTURE;
                        busy             <= 1'b1;
                    end else if (state == DONE) begin
                        state <= continuous ? ARM : IDLE;
                        busy  <= continuous;
                    end
                end

                CAPTURE: begin
                    if (pix_valid) begin
                        if (seq_hit) begin
                            back_buf[buf_pos] <= fg_bit;
                            if (last_hit) begin
                                // Publish with the final pixel merged in at bit 0.
                                image       <= {back_buf[NPIX-1:1], fg_bit};
                                frame_valid <= 1'b1;
                                state       <= DONE;
                                busy        <= 1'b0;
                            end else begin
                                exp_idx <= exp_idx + IDX_W'(1);
                            end
                        end else begin
                            sync_err <= 1'b1;
`ifdef FRAME_CAPTURE_ERRCNT_EN
                            if (err_count != '1) begin
                                err_count <= err_count + ERRCNT_W'(1);
                            end
`endif
                            // An aborting pixel that is itself a start pixel
                            // opens a fresh frame immediately.
                            if (start_hit) begin
                                back_buf[NPIX-1] <= fg_bit;
                                exp_idx          <= IDX_W'(1);
                            end else begin
                                state <= ARM;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : frame_capture
